// File: rtl/wb_bus_arbiter.sv
// Two-master (instruction/data) to one-slave classic Wishbone arbiter
// with round-robin or data-first arbitration and a bus watchdog.
`timescale 1ns/1ps

module wb_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          RR_ENABLE      = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        iwbs_cyc_i,
    input  logic        iwbs_stb_i,
    input  logic [31:0] iwbs_addr_i,
    output logic        iwbs_ack_o,
    output logic        iwbs_err_o,
    output logic [31:0] iwbs_dat_o,

    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    input  logic        dwbs_we_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o,
    output logic [31:0] dwbs_dat_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_e;

    localparam bit          WD_ON   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;

    logic i_req, d_req;
    logic gnt_d, m_cyc, m_stb;
    logic wd_fire, term_ack, term_err;

    assign i_req = iwbs_cyc_i & iwbs_stb_i;
    assign d_req = dwbs_cyc_i & dwbs_stb_i;

    assign gnt_d = (state_q == GNT_D);
    assign m_cyc = gnt_d ? dwbs_cyc_i : iwbs_cyc_i;
    assign m_stb = gnt_d ? dwbs_stb_i : iwbs_stb_i;

    // A real slave response always wins over the watchdog in the same cycle
    assign wd_fire  = WD_ON && (wd_cnt_q == WD_LAST)
                      && !wbm_ack_i && !wbm_err_i;
    assign term_err = m_cyc & (wbm_err_i | wd_fire);
    assign term_ack = m_cyc & wbm_ack_i & ~wbm_err_i;

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        wd_cnt_d   = wd_cnt_q;
        iwbs_ack_o = 1'b0;
        iwbs_err_o = 1'b0;
        iwbs_dat_o = '0;
        dwbs_ack_o = 1'b0;
        dwbs_err_o = 1'b0;
        dwbs_dat_o = '0;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_sel_o  = '0;
        wbm_addr_o = '0;
        wbm_dat_o  = '0;
        grant_o    = 2'b00;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    if (d_req && (!i_req || !RR_ENABLE || !last_d_q)) begin
                        state_d  = GNT_D;
                        last_d_d = 1'b1;
                    end else begin
                        state_d  = GNT_I;
                        last_d_d = 1'b0;
                    end
                    wd_cnt_d = '0;
                end
            end
            GNT_I, GNT_D: begin
                grant_o    = gnt_d ? 2'b10 : 2'b01;
                wbm_cyc_o  = m_cyc & ~wd_fire;
                wbm_stb_o  = m_stb & ~wd_fire;
                wbm_we_o   = gnt_d & dwbs_we_i;
                wbm_sel_o  = gnt_d ? dwbs_sel_i : 4'hF;
                wbm_addr_o = gnt_d ? dwbs_addr_i : iwbs_addr_i;
                wbm_dat_o  = gnt_d ? dwbs_dat_i : '0;
                iwbs_dat_o = wbm_dat_i;
                dwbs_dat_o = wbm_dat_i;
                iwbs_ack_o = ~gnt_d & term_ack;
                iwbs_err_o = ~gnt_d & term_err;
                dwbs_ack_o = gnt_d & term_ack;
                dwbs_err_o = gnt_d & term_err;
                if (!m_cyc || wbm_ack_i || wbm_err_i || wd_fire) begin
                    state_d = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Nothing leaks to either side while reset is held
        if (rst_i) begin
            iwbs_ack_o = 1'b0;
            iwbs_err_o = 1'b0;
            iwbs_dat_o = '0;
            dwbs_ack_o = 1'b0;
            dwbs_err_o = 1'b0;
            dwbs_dat_o = '0;
            wbm_cyc_o  = 1'b0;
            wbm_stb_o  = 1'b0;
            wbm_we_o   = 1'b0;
            wbm_sel_o  = '0;
            wbm_addr_o = '0;
            wbm_dat_o  = '0;
            grant_o    = 2'b00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps

module tb_wb_bus_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    logic i_cyc, i_stb;
    logic [31:0] i_addr;
    logic d_cyc, d_stb, d_we;
    logic [3:0] d_sel;
    logic [31:0] d_addr, d_dat;
    logic ack_in, err_in;
    logic [31:0] sdat;

    logic i_ack, i_err, d_ack, d_err;
    logic [31:0] i_rdat, d_rdat;
    logic m_cyc, m_stb, m_we;
    logic [3:0] m_sel;
    logic [31:0] m_addr, m_wdat;
    logic [1:0] grant;

    logic r_i_ack, r_i_err, r_d_ack, r_d_err;
    logic [31:0] r_i_rdat, r_d_rdat;
    logic r_m_cyc, r_m_stb, r_m_we;
    logic [3:0] r_m_sel;
    logic [31:0] r_m_addr, r_m_wdat;
    logic [1:0] r_grant;

    wire [140:0] all_out = {i_ack, i_err, i_rdat, d_ack, d_err, d_rdat,
                            m_cyc, m_stb, m_we, m_sel, m_addr, m_wdat, grant};
    wire [140:0] r_all = {r_i_ack, r_i_err, r_i_rdat, r_d_ack, r_d_err,
                          r_d_rdat, r_m_cyc, r_m_stb, r_m_we, r_m_sel,
                          r_m_addr, r_m_wdat, r_grant};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.TIMEOUT_CYCLES(TO), .RR_ENABLE(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .iwbs_cyc_i(i_cyc), .iwbs_stb_i(i_stb), .iwbs_addr_i(i_addr),
        .iwbs_ack_o(i_ack), .iwbs_err_o(i_err), .iwbs_dat_o(i_rdat),
        .dwbs_cyc_i(d_cyc), .dwbs_stb_i(d_stb), .dwbs_we_i(d_we),
        .dwbs_sel_i(d_sel), .dwbs_addr_i(d_addr), .dwbs_dat_i(d_dat),
        .dwbs_ack_o(d_ack), .dwbs_err_o(d_err), .dwbs_dat_o(d_rdat),
        .wbm_cyc_o(m_cyc), .wbm_stb_o(m_stb), .wbm_we_o(m_we),
        .wbm_sel_o(m_sel), .wbm_addr_o(m_addr), .wbm_dat_o(m_wdat),
        .wbm_ack_i(ack_in), .wbm_err_i(err_in), .wbm_dat_i(sdat),
        .grant_o(grant)
    );

    wb_bus_arbiter #(.TIMEOUT_CYCLES(0), .RR_ENABLE(1'b0)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .iwbs_cyc_i(i_cyc), .iwbs_stb_i(i_stb), .iwbs_addr_i(i_addr),
        .iwbs_ack_o(r_i_ack), .iwbs_err_o(r_i_err), .iwbs_dat_o(r_i_rdat),
        .dwbs_cyc_i(d_cyc), .dwbs_stb_i(d_stb), .dwbs_we_i(d_we),
        .dwbs_sel_i(d_sel), .dwbs_addr_i(d_addr), .dwbs_dat_i(d_dat),
        .dwbs_ack_o(r_d_ack), .dwbs_err_o(r_d_err), .dwbs_dat_o(r_d_rdat),
        .wbm_cyc_o(r_m_cyc), .wbm_stb_o(r_m_stb), .wbm_we_o(r_m_we),
        .wbm_sel_o(r_m_sel), .wbm_addr_o(r_m_addr), .wbm_dat_o(r_m_wdat),
        .wbm_ack_i(ack_in), .wbm_err_i(err_in), .wbm_dat_i(sdat),
        .grant_o(r_grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_cyc = 0; i_stb = 0; i_addr = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_sel = '0;
        d_addr = '0; d_dat = '0;
        ack_in = 0; err_in = 0; sdat = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
        ack_in = 1; sdat = 32'h1234_5678;
        tick(); tick(); #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        checks++;
        if (r_all !== '0) begin
            errors++;
            $display("FAIL reset_outputs_fp: got %h want 0", r_all);
        end
        rst = 0;
        idle_inputs();
        tick(); #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got %h want 0", all_out);
        end
    endtask

    task automatic test_ifetch();
        tick();
        i_cyc = 1; i_stb = 1; i_addr = 32'h8000_0000;
        #1;
        checks++;
        if (grant !== 2'b00 || m_addr !== 32'h0) begin
            errors++;
            $display("FAIL arb_latency: got grant %b addr %h want 00 0", grant, m_addr);
        end
        tick(); #1;
        checks++;
        if ({grant, m_cyc, m_stb, m_we, m_sel, m_addr} !==
            {2'b01, 1'b1, 1'b1, 1'b0, 4'hF, 32'h8000_0000}) begin
            errors++;
            $display("FAIL ifetch_req: got grant %b cyc %b we %b sel %h addr %h want 01 1 0 f 80000000",
                     grant, m_cyc, m_we, m_sel, m_addr);
        end
        tick();
        ack_in = 1; sdat = 32'h0000_0013;
        #1;
        checks++;
        if ({i_ack, i_err, d_ack, i_rdat, d_rdat} !==
            {1'b1, 1'b0, 1'b0, 32'h13, 32'h13}) begin
            errors++;
            $display("FAIL ifetch_ack: got iack %b dack %b idat %h ddat %h want 1 0 13 13",
                     i_ack, d_ack, i_rdat, d_rdat);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if ({grant, i_ack} !== 3'b000) begin
            errors++;
            $display("FAIL ifetch_done: got grant %b ack %b want 00 0", grant, i_ack);
        end
    endtask

    task automatic test_store();
        tick();
        d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 4'b0011;
        d_addr = 32'h1000; d_dat = 32'hDEAD_BEEF;
        tick(); #1;
        checks++;
        if ({grant, m_we, m_sel, m_addr, m_wdat} !==
            {2'b10, 1'b1, 4'b0011, 32'h1000, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL store_pass: got grant %b we %b sel %b addr %h dat %h want 10 1 0011 1000 deadbeef",
                     grant, m_we, m_sel, m_addr, m_wdat);
        end
        i_cyc = 1; i_stb = 1; i_addr = 32'h0000_0100;
        tick();
        ack_in = 1;
        #1;
        checks++;
        if ({grant, d_ack, i_ack} !== 4'b1010) begin
            errors++;
            $display("FAIL store_ack: got grant %b dack %b iack %b want 10 1 0", grant, d_ack, i_ack);
        end
        tick();
        ack_in = 0; d_cyc = 0; d_stb = 0; d_we = 0;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL store_gap: got grant %b want 00", grant);
        end
        tick(); #1;
        checks++;
        if ({grant, m_addr, m_we, m_sel} !== {2'b01, 32'h100, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL store_pending_i: got grant %b addr %h we %b sel %h want 01 100 0 f",
                     grant, m_addr, m_we, m_sel);
        end
        tick();
        ack_in = 1;
        #1;
        checks++;
        if (i_ack !== 1'b1) begin
            errors++;
            $display("FAIL store_i_ack: got %b want 1", i_ack);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_round_robin();
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        i_cyc = 1; i_stb = 1; i_addr = 32'h40;
        d_cyc = 1; d_stb = 1; d_addr = 32'h80;
        ack_in = 1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] eg;
            eg = (k % 2 == 1) ? 2'b01 : 2'b10;
            tick(); #1;
            checks++;
            if ({grant, r_grant, d_ack, i_ack} !== {eg, 2'b10, eg}) begin
                errors++;
                $display("FAIL rr_grant_%0d: got grant %b fp %b dack %b iack %b want %b 10 %b",
                         k, grant, r_grant, d_ack, i_ack, eg, eg);
            end
            tick(); #1;
            checks++;
            if ({grant, d_ack, i_ack} !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap_%0d: got grant %b dack %b iack %b want 00 0 0",
                         k, grant, d_ack, i_ack);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        d_cyc = 1; d_stb = 1; d_we = 0; d_addr = 32'h2000;
        for (int g = 1; g <= 4; g++) begin
            tick();
            if (g == 1) begin
                i_cyc = 1; i_stb = 1; i_addr = 32'h3000;
            end
            #1;
            if (g < 4) begin
                checks++;
                if ({d_err, m_cyc, grant} !== 4'b0110) begin
                    errors++;
                    $display("FAIL wd_wait_%0d: got err %b cyc %b grant %b want 0 1 10",
                             g, d_err, m_cyc, grant);
                end
            end else begin
                checks++;
                if ({d_err, d_ack, i_err, m_cyc, m_stb, grant} !== 7'b1000010) begin
                    errors++;
                    $display("FAIL wd_fire: got derr %b dack %b ierr %b cyc %b stb %b grant %b want 1 0 0 0 0 10",
                             d_err, d_ack, i_err, m_cyc, m_stb, grant);
                end
                checks++;
                if ({r_d_err, r_m_cyc, r_grant} !== 4'b0110) begin
                    errors++;
                    $display("FAIL wd_off: got err %b cyc %b grant %b want 0 1 10",
                             r_d_err, r_m_cyc, r_grant);
                end
            end
        end
        tick();
        d_cyc = 0; d_stb = 0;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL wd_idle: got grant %b want 00", grant);
        end
        tick(); #1;
        checks++;
        if ({grant, m_addr} !== {2'b01, 32'h3000}) begin
            errors++;
            $display("FAIL wd_then_i: got grant %b addr %h want 01 3000", grant, m_addr);
        end
        tick();
        ack_in = 1;
        #1;
        checks++;
        if (i_ack !== 1'b1) begin
            errors++;
            $display("FAIL wd_i_ack: got %b want 1", i_ack);
        end
        tick();
        idle_inputs();
        ack_in = 1;
        #1;
        checks++;
        if ({i_ack, d_ack, i_err, d_err, grant} !== 6'b0) begin
            errors++;
            $display("FAIL late_ack: got %b want 000000", {i_ack, d_ack, i_err, d_err, grant});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_ack_err();
        d_cyc = 1; d_stb = 1; d_addr = 32'h44;
        tick(); tick();
        ack_in = 1; err_in = 1;
        #1;
        checks++;
        if ({d_err, d_ack, i_err, i_ack} !== 4'b1000) begin
            errors++;
            $display("FAIL ack_err: got derr %b dack %b ierr %b iack %b want 1 0 0 0",
                     d_err, d_ack, i_err, i_ack);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_abort();
        i_cyc = 1; i_stb = 1; i_addr = 32'h88;
        tick(); #1;
        checks++;
        if ({grant, m_cyc} !== 3'b011) begin
            errors++;
            $display("FAIL abort_grant: got grant %b cyc %b want 01 1", grant, m_cyc);
        end
        tick();
        i_cyc = 0; ack_in = 1;
        #1;
        checks++;
        if ({m_cyc, i_ack, i_err} !== 3'b000) begin
            errors++;
            $display("FAIL abort_drop: got cyc %b ack %b err %b want 0 0 0", m_cyc, i_ack, i_err);
        end
        tick();
        ack_in = 0;
        #1;
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle: got grant %b want 00", grant);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        d_cyc = 1; d_stb = 1; d_addr = 32'h500;
        tick(); tick();
        rst = 1; ack_in = 1; sdat = 32'hCAFE_F00D;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rst_mid_same: got %h want 0", all_out);
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL rst_mid_next: got %h want 0", all_out);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int own, last, age, mism;
        bit ip, dp, fin;
        logic [31:0] ia, da, dd;
        logic dw;
        logic [3:0] ds;
        logic e_ack, e_err, e_cyc, e_stb, e_we;
        logic [3:0] e_sel;
        logic [31:0] e_addr, e_wdat, e_rdat;
        logic [1:0] e_grant;
        logic [140:0] exp_v;

        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        own = 0; last = 1; age = 0; ip = 0; dp = 0; mism = 0;
        ia = '0; da = '0; dd = '0; dw = 0; ds = '0;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (!ip && $urandom_range(0, 3) == 0) begin
                ip = 1; ia = $urandom;
            end
            if (!dp && $urandom_range(0, 3) == 0) begin
                dp = 1; da = $urandom; dd = $urandom;
                dw = 1'($urandom_range(0, 1)); ds = 4'($urandom);
            end
            i_cyc = ip; i_stb = ip; i_addr = ia;
            d_cyc = dp; d_stb = dp; d_we = dw; d_sel = ds;
            d_addr = da; d_dat = dd;
            ack_in = ($urandom_range(0, 2) == 0);
            err_in = ($urandom_range(0, 7) == 0);
            sdat = $urandom;
            #1;
            e_ack = 0; e_err = 0; e_cyc = 0; e_stb = 0; e_we = 0;
            e_sel = '0; e_addr = '0; e_wdat = '0; e_rdat = '0; e_grant = 2'b00;
            if (own == 0) begin
                if (ip && dp) begin
                    own = (last == 1) ? 2 : 1;
                end else if (dp) begin
                    own = 2;
                end else if (ip) begin
                    own = 1;
                end
                if (own != 0) begin
                    last = own;
                    age = 0;
                end
                exp_v = '0;
            end else begin
                e_grant = (own == 2) ? 2'b10 : 2'b01;
                e_cyc = 1; e_stb = 1;
                e_addr = (own == 2) ? da : ia;
                e_we = (own == 2) && dw;
                e_sel = (own == 2) ? ds : 4'hF;
                e_wdat = (own == 2) ? dd : 32'h0;
                e_rdat = sdat;
                fin = 1;
                if (err_in) begin
                    e_err = 1;
                end else if (ack_in) begin
                    e_ack = 1;
                end else if (age == TO - 1) begin
                    e_err = 1; e_cyc = 0; e_stb = 0;
                end else begin
                    fin = 0;
                    age++;
                end
                if (own == 2) begin
                    exp_v = {2'b00, e_rdat, e_ack, e_err, e_rdat, e_cyc, e_stb,
                             e_we, e_sel, e_addr, e_wdat, e_grant};
                end else begin
                    exp_v = {e_ack, e_err, e_rdat, 2'b00, e_rdat, e_cyc, e_stb,
                             e_we, e_sel, e_addr, e_wdat, e_grant};
                end
                if (fin) begin
                    if (own == 2) dp = 0;
                    else ip = 0;
                    own = 0;
                end
            end
            checks++;
            if (all_out !== exp_v) begin
                errors++;
                mism++;
                if (mism <= 5)
                    $display("FAIL random_cycle_%0d: got %h want %h", n, all_out, exp_v);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL time_limit: got still running want finished");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_ifetch();
        test_store();
        test_round_robin();
        test_timeout();
        test_ack_err();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
